// File: rtl/updown_dir_ctrl.sv
// updown_dir_ctrl: direction controller for a CNT_W-bit up/down saturating counter.
// It debounces a push-button into a one-cycle toggle pulse. In auto mode it reverses
// direction when the fed-back count reaches either limit.
// Optional feature: define DIR_CTRL_SYNC_EN to put a 2-flop synchronizer on btn_raw.
module updown_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  output logic             sel,
  output logic             toggle_pulse,
  output logic             at_limit
);

  localparam int unsigned    DW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0]  DcntLast = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  localparam logic StUp   = 1'b0;
  localparam logic StDown = 1'b1;

  logic          btn_s;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          toggle_q, toggle_d;
  logic          state_q, state_d;
  logic          at_limit_q, at_limit_d;
  logic          up_lim, dn_lim;

`ifdef DIR_CTRL_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for an asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn_raw;
`endif

  // Debouncer: the level must differ for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (btn_s != stable_q) begin
      if (dcnt_q == DcntLast) begin
        stable_d = btn_s;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    // Pulse only on the debounced press; a release makes no pulse.
    toggle_d = stable_d & ~stable_q;
  end

  // Direction next state; in auto mode a limit reversal overrides a toggle.
  always_comb begin
    up_lim     = (state_q == StUp) && (count == CntMax);
    dn_lim     = (state_q == StDown) && (count == '0);
    at_limit_d = up_lim | dn_lim;
    state_d    = state_q;
    if (mode && up_lim) begin
      state_d = StDown;
    end else if (mode && dn_lim) begin
      state_d = StUp;
    end else if (toggle_q) begin
      state_d = ~state_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q   <= 1'b0;
      dcnt_q     <= '0;
      toggle_q   <= 1'b0;
      state_q    <= StUp;
      at_limit_q <= 1'b0;
    end else begin
      stable_q   <= stable_d;
      dcnt_q     <= dcnt_d;
      toggle_q   <= toggle_d;
      state_q    <= state_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign sel          = (state_q == StDown);
  assign toggle_pulse = toggle_q;
  assign at_limit     = at_limit_q;

endmodule

// File: doc/updown_dir_ctrl.md
# updown_dir_ctrl

Direction controller sitting directly upstream of the 4-bit up/down saturating counter; it drives the counter's `sel` input (0 = count up, 1 = count down) from the same clock. It debounces a raw push-button into a single-cycle toggle pulse for manual direction changes. In auto mode it watches the counter's `out` value fed back on `count` and reverses direction at 15 and 0, producing a continuous up/down bounce.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive samples of a changed level required before the debounced level updates; legal range ≥1.
- `CNT_W`, default 4: width of `count`; the upper limit is 2^CNT_W−1.

- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `btn_raw`  in  1  raw direction push-button, may bounce or be asynchronous.
- `mode`  in  1  0 = manual (button toggles direction); 1 = auto bounce.
- `count`  in  CNT_W  counter output, fed back.
- `sel`  out  1  direction to the counter; 1 = down.
- `toggle_pulse`  out  1  one-cycle pulse on each debounced button press (0→1).
- `at_limit`  out  1  registered flag: the counter sat at the limit of its current direction on the previous edge.

## Operation
- Input path: `btn_raw` passes through the optional synchronizer (see Configuration) to give `btn_s`.
- Debouncer: registers `stable` and `dcnt` (width $clog2(DEBOUNCE_CYCLES)+1).
  - If `btn_s == stable`, then `dcnt` <= 0.
  - Otherwise `dcnt` increments. On the DEBOUNCE_CYCLES-th consecutive mismatch, `stable` <= `btn_s` and `dcnt` <= 0.
  - A single matching sample restarts the count.
- `toggle_pulse` is a register. It is set to 1 at the edge where `stable` goes 0→1 and to 0 at every other edge. A release (1→0) produces no pulse.
- Direction FSM has two states, UP and DOWN; `sel` = (state == DOWN), registered.
  - mode=0: a `toggle_pulse` of 1 flips the state at the next edge.
  - mode=1, UP with `count` == 2^CNT_W−1: go to DOWN.
  - mode=1, DOWN with `count` == 0: go to UP.
  - mode=1: `toggle_pulse` also flips the state, unless a limit reversal fires in the same cycle. In that case the limit reversal wins and the state moves away from the limit.
  - Changing `mode` never changes the state by itself; the next edge applies the new rules.
- `at_limit` <= (UP && `count` == max) || (DOWN && `count` == 0). The condition is evaluated with the pre-edge state in both modes.

## Timing
- Reset (asynchronous, immediate) clears state to UP and sets `sel`, `toggle_pulse`, `at_limit`, `stable`, `dcnt` and synchronizer flops to 0.
- An assertion of `rst` mid-debounce or mid-bounce discards all progress; operation restarts from UP after release.
- Button latency, with synchronizer, measured from a level stable before edge 1:
  - `btn_s` valid after edge 2.
  - `stable` and `toggle_pulse` go to 1 after edge 2+DEBOUNCE_CYCLES.
  - `sel` flips after edge 3+DEBOUNCE_CYCLES.
- Without the synchronizer, subtract 2 edges from each of the above.
- Auto reversal: `count` == 15 while UP before edge n gives `sel`=1 and `at_limit`=1 after edge n. The counter samples `sel`=1 at edge n+1, so the counter sits at 15 for exactly one extra edge.
- `toggle_pulse` is never high for two consecutive cycles.

## Configuration
- `DIR_CTRL_SYNC_EN` defined: a 2-flop synchronizer (reset to 0) sits in front of the debouncer, giving the latencies stated above.
- Macro undefined: `btn_s` = `btn_raw` directly. Use this only for a synchronous `btn_raw`. Every latency shrinks by 2 cycles and all other behaviour is identical.

## Test plan
- Reset: assert `rst` between clock edges → `sel`, `toggle_pulse`, `at_limit` read 0 immediately, without waiting for an edge.
- Debounce, macro defined, DEBOUNCE_CYCLES=4, mode=0: hold `btn_raw`=1 → `toggle_pulse`=1 for one cycle after edge 6, `sel`=1 after edge 7; release and press again → `sel`=0.
- Bounce rejection: toggle `btn_raw` 1,0,1,0 on successive cycles, then hold it low → `toggle_pulse` stays 0 and `sel` is unchanged.
- Auto bounce with a counter model in the loop, mode=1, from reset:
  - count rises 0→15; `sel`=1 and `at_limit`=1 after the edge at which the model's output (`count`) is 15.
  - count falls to 0 and `sel` returns to 0; the count sequence is periodic with 15 and 0 each seen for two edges.
- Collision: mode=1, UP, `count`=15 and `toggle_pulse`=1 in the same cycle → state goes to DOWN (limit wins) and no second flip occurs.
- Mid-operation reset: assert `rst` while DOWN with `dcnt`=2 → after release `sel`=0, and a fresh full DEBOUNCE_CYCLES window is required for the next toggle.
